// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, sign fixup, registered result with a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  // Handshake: an operation is accepted on an edge where the unit is IDLE,
  // start_i=1 and flush_i=0. stall_o holds the pipeline from the request
  // cycle through FIXUP; done_o marks the single cycle result_o is new.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] mag_b_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] result_q;

  // Operand decode at acceptance
  logic             a_signed, b_signed;
  logic             a_is_neg, b_is_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;
  logic             accept;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (funct3_i[2]) begin
      a_signed = ~funct3_i[0];
      b_signed = ~funct3_i[0];
    end else begin
      a_signed = (funct3_i[1:0] != 2'b11);
      b_signed = ~funct3_i[1];
    end
  end

  assign a_is_neg = a_signed & a_i[WIDTH-1];
  assign b_is_neg = b_signed & b_i[WIDTH-1];
  assign a_mag    = a_is_neg ? -a_i : a_i;
  assign b_mag    = b_is_neg ? -b_i : b_i;

  assign div_zero = funct3_i[2] && (b_i == '0);
  assign div_ovf  = funct3_i[2] && !funct3_i[0] &&
                    (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3_i[1] ? a_i : '1;
    end else if (div_ovf) begin
      special_res = funct3_i[1] ? '0 : a_i;
    end
  end

  assign accept = (state_q == S_IDLE) && start_i && !flush_i;

  // One multiply step: conditional add of the multiplicand, then shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
  assign mul_next = {mul_sum, acc_lo_q[WIDTH-1:1]};

  // One restoring-divide step: remainder in acc_hi, dividend/quotient in acc_lo
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_bit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_bit   = ~div_diff[WIDTH];
  assign div_rem   = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_lo_q[WIDTH-2:0], div_bit};

  // Sign fixup and result selection
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_raw = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_q_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    fix_res = '0;
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fix_res = prod_fix[WIDTH-1:0];
    end else begin
      fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  logic last_iter;
  assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = flush_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      mag_b_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= funct3_i;
            mag_b_q  <= b_mag;
            neg_q_q  <= a_is_neg ^ b_is_neg;
            neg_r_q  <= a_is_neg;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
            if (special) begin
              result_q <= special_res;
            end
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            {acc_hi_q, acc_lo_q} <= op_q[2] ? div_next : mul_next;
          end
        end
        S_FIXUP: begin
          if (!flush_i) begin
            result_q <= fix_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign stall_o  = ((state_q == S_IDLE) && start_i) || busy_o;
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, stall length,
// special cases, flush, back-to-back and reset behaviour.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             flush_i;
  logic [2:0]       funct3_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    a_i      = $urandom;
    b_i      = $urandom;
    funct3_i = 3'($urandom_range(0, 7));
  endtask

  // Called in the cycle after acceptance; returns cycles since the accept cycle
  task automatic wait_done(output int lat, output int stalls);
    lat    = 1;
    stalls = 0;
    while (!done_o && lat < 100) begin
      if (stall_o) stalls++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat, stalls;
    start_i  = 1'b1;
    funct3_i = f3;
    a_i      = a;
    b_i      = b;
    #1;
    check({tag, "_stall_req"}, 32'(stall_o), 32'd1);
    tick();
    start_i = 1'b0;
    scramble();
    wait_done(lat, stalls);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
    check({tag, "_result"}, result_o, exp);
    tick();
    check({tag, "_done_drop"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int lat, stalls;
    rst      = 1'b1;
    start_i  = 1'b1;
    flush_i  = 1'b0;
    funct3_i = 3'b101;
    a_i      = 32'd100;
    b_i      = 32'd7;

    // Reset held two cycles with start asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_result", result_o, 32'd0);
    end
    rst = 1'b0;

    // First start after release is accepted
    run_op("mul",    3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 34);
    run_op("mulh",   3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 34);
    run_op("mulhu",  3'b011, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 34);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 34);
    run_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mulhsu_min", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);

    run_op("div",   3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
    run_op("rem",   3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
    run_op("divu",  3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34);
    run_op("remu",  3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 34);
    run_op("div_negb", 3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    run_op("rem_negb", 3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34);

    // Special cases complete one cycle after acceptance
    run_op("divu_zero", 3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1);
    run_op("rem_zero",  3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 1);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Flush in IDLE beats start
    start_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = 3'b101;
    a_i      = 32'h1;
    b_i      = 32'h0;
    tick();
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_idle_done", 32'(done_o), 32'd0);
    check("flush_idle_busy", 32'(busy_o), 32'd0);
    check("flush_idle_result", result_o, 32'h80000000);

    // Flush during CALC at counter 10
    start_i  = 1'b1;
    funct3_i = 3'b000;
    a_i      = 32'd5;
    b_i      = 32'd6;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("flush_calc_busy_before", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_calc_busy", 32'(busy_o), 32'd0);
    check("flush_calc_done", 32'(done_o), 32'd0);
    check("flush_calc_result", result_o, 32'h80000000);
    run_op("mul_after_flush", 3'b000, 32'd5, 32'd6, 32'd30, 34);

    // Back-to-back with start held high
    start_i  = 1'b1;
    funct3_i = 3'b101;
    a_i      = 32'd100;
    b_i      = 32'd7;
    tick();
    funct3_i = 3'b111;
    wait_done(lat, stalls);
    check("b2b_first_latency", 32'(lat), 32'd34);
    check("b2b_first_result", result_o, 32'd14);
    check("b2b_done_stall", 32'(stall_o), 32'd0);
    tick();
    check("b2b_idle_busy", 32'(busy_o), 32'd0);
    check("b2b_idle_stall", 32'(stall_o), 32'd1);
    tick();
    start_i = 1'b0;
    scramble();
    wait_done(lat, stalls);
    check("b2b_second_latency", 32'(lat), 32'd34);
    check("b2b_second_result", result_o, 32'd2);
    tick();

    // Reset mid-operation
    start_i  = 1'b1;
    funct3_i = 3'b000;
    a_i      = 32'd9;
    b_i      = 32'd9;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o) check("midrst_no_done", 32'(done_o), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
